// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset/lock sequencer.
package pll_seq_pkg;

  localparam int CNT_W  = 16;
  localparam int LOST_W = 8;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } seq_state_t;

  // Output levels for a given state: {pll_rst, sys_rst, ready}
  function automatic logic [2:0] state_outputs(seq_state_t s);
    case (s)
      PLL_RST: state_outputs = 3'b110;
      RUN:     state_outputs = 3'b001;
      default: state_outputs = 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, then
// releases system reset; re-runs the sequence on loss, relock or timeout.
//
// state     | meaning
// PLL_RST   | PLL reset asserted for PLL_RST_CYCLES
// WAIT_LOCK | waiting for lock, bounded by LOCK_TIMEOUT
// STABLE    | lock must stay high LOCK_STABLE_CYCLES
// HOLD      | system reset held SYS_RST_HOLD more cycles
// RUN       | system out of reset, ready
module pll_rst_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int SYS_RST_HOLD       = 32,
  parameter int LOCK_TIMEOUT       = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pll_locked,
  input  logic              i_relock_req,
  output logic              o_pll_rst,
  output logic              o_sys_rst,
  output logic              o_ready,
  output logic              o_timeout,
  output logic [LOST_W-1:0] o_lost_cnt
);

  localparam logic [CNT_W-1:0] TC_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_HOLD    = CNT_W'(SYS_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TC_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);

  seq_state_t       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             timeout_hit;
  logic             loss_hit;

  sync_2ff u_lock_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_pll_locked),
    .q   (lock_s)
  );

  // Lock arriving on the timeout cycle takes priority, so no timeout is flagged.
  always_comb begin
    nxt         = state;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == TC_PLL_RST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt = STABLE;
        end else if (cnt == TC_TIMEOUT) begin
          nxt         = PLL_RST;
          timeout_hit = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                nxt = WAIT_LOCK;
        else if (cnt == TC_STABLE)  nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)                nxt = WAIT_LOCK;
        else if (cnt == TC_HOLD)    nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          nxt      = PLL_RST;
          loss_hit = 1'b1;
        end else if (i_relock_req) begin
          nxt = PLL_RST;
        end
      end
      default: nxt = PLL_RST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      o_pll_rst  <= 1'b1;
      o_sys_rst  <= 1'b1;
      o_ready    <= 1'b0;
      o_timeout  <= 1'b0;
      o_lost_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (state != RUN)
        cnt <= cnt + 16'd1;
      {o_pll_rst, o_sys_rst, o_ready} <= state_outputs(nxt);
      if (timeout_hit)
        o_timeout <= 1'b1;
      if (loss_hit && (o_lost_cnt != {LOST_W{1'b1}}))
        o_lost_cnt <= o_lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer with a per-cycle expected-output scoreboard.
module tb_pll_rst_sequencer;

  localparam int PRC    = 4;
  localparam int LSC    = 8;
  localparam int SRH    = 4;
  localparam int LTO    = 100;
  localparam int RUN_AT = PRC + 1 + LSC + SRH;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout;
  logic [7:0] lost_cnt;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] lc, nlc;

  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .SYS_RST_HOLD       (SRH),
    .LOCK_TIMEOUT       (LTO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pll_locked (locked),
    .i_relock_req (relock),
    .o_pll_rst    (pll_rst),
    .o_sys_rst    (sys_rst),
    .o_ready      (ready),
    .o_timeout    (timeout),
    .o_lost_cnt   (lost_cnt)
  );

  function automatic logic [11:0] ov(input logic pr, input logic sr, input logic rd,
                                     input logic to, input logic [7:0] c);
    return {pr, sr, rd, to, c};
  endfunction

  task automatic push(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [11:0] obs;
    obs = {pll_rst, sys_rst, ready, timeout, lost_cnt};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h (pll_rst,sys_rst,ready,timeout,lost[7:0])",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_pop();
    end
  endtask

  // Expected outputs for a sequence entered at relative edge 0 with lock_s already high.
  task automatic push_seq(input string tag, input int run_at, input logic to,
                          input logic [7:0] c);
    for (int k = 1; k <= run_at; k++)
      push(tag, ov(k < PRC, k < run_at, k == run_at, to, c));
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    relock = 1'b0;
    #2;
    push("reset_vals", ov(1, 1, 0, 0, 0));
    check_pop();
    rst = 1'b0;

    // Lock never arrives: two full timeout retries.
    for (int k = 1; k < PRC; k++)              push("to_prst1", ov(1, 1, 0, 0, 0));
    for (int k = 0; k < LTO; k++)              push("to_wait1", ov(0, 1, 0, 0, 0));
    for (int k = 0; k < PRC; k++)              push("to_prst2", ov(1, 1, 0, 1, 0));
    for (int k = 0; k < LTO; k++)              push("to_wait2", ov(0, 1, 0, 1, 0));
    push("to_prst3", ov(1, 1, 0, 1, 0));
    cyc(2 * PRC + 2 * LTO);

    rst = 1'b1;
    #2;
    push("rst_clears_to", ov(1, 1, 0, 0, 0));
    check_pop();
    locked = 1'b1;
    #2;
    rst = 1'b0;

    push_seq("bringup", RUN_AT, 0, 0);
    cyc(RUN_AT);

    // Relock from RUN, with an ignored relock pulse during HOLD.
    relock = 1'b1;
    push("relock_edge", ov(1, 1, 0, 0, 0));
    cyc(1);
    relock = 1'b0;
    push_seq("relock_rerun", RUN_AT, 0, 0);
    cyc(PRC + LSC + 2);
    relock = 1'b1;
    cyc(1);
    relock = 1'b0;
    cyc(RUN_AT - (PRC + LSC + 3));

    // One-cycle lock glitch at STABLE cycle 5 forces a full requalification.
    relock = 1'b1;
    push("relock_edge2", ov(1, 1, 0, 0, 0));
    cyc(1);
    relock = 1'b0;
    push_seq("glitch", RUN_AT + 8, 0, 0);
    cyc(PRC + 5);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    cyc(RUN_AT + 8 - (PRC + 6));

    // Repeated lock losses in RUN; counter saturates at 255.
    lc = 8'd0;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      nlc = (lc == 8'hFF) ? lc : lc + 8'd1;
      push("loss_sync1", ov(0, 0, 1, 0, lc));
      push("loss_sync2", ov(0, 0, 1, 0, lc));
      push("loss_edge3", ov(1, 1, 0, 0, nlc));
      cyc(3);
      locked = 1'b1;
      lc = nlc;
      push_seq("loss_rerun", RUN_AT, 0, lc);
      cyc(RUN_AT);
    end

    rst = 1'b1;
    #2;
    push("arst_run", ov(1, 1, 0, 0, 0));
    check_pop();
    #2;
    rst = 1'b0;

    for (int k = 1; k <= PRC + 1 + LSC + 1; k++)
      push("to_hold", ov(k < PRC, 1, 0, 0, 0));
    cyc(PRC + 1 + LSC + 1);
    rst = 1'b1;
    #2;
    push("arst_hold", ov(1, 1, 0, 0, 0));
    check_pop();
    #2;
    rst = 1'b0;

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
